// File: rtl/protobuf_pkg.sv
// Shared types for the protobuf ingress path: scheduler state encoding
// and a small index-width helper.
package protobuf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        STREAM,
        DRAIN,
        FLUSH
    } proto_sched_state_t;

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/proto_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the
// pointer, wrapping around the source vector.
module proto_rr_arbiter
    import protobuf_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    always_comb begin
        int j;
        onehot  = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            j = (int'(ptr) + i) % NUM_SRC;
            if (!any_req && req[j]) begin
                any_req   = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/proto_stream_sched.sv
// Round-robin owner of a shared protobuf deserializer: forwards one
// length-prefixed message per grant, then flushes the deserializer.
module proto_stream_sched
    import protobuf_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int LEN_W        = 16,
    parameter int STALL_MAX    = 1024,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_SRC-1:0]       req_i,
    input  logic [NUM_SRC*LEN_W-1:0] req_len_i,
    input  logic [NUM_SRC*32-1:0]    req_addr_i,
    input  logic [NUM_SRC*8-1:0]     src_data_i,
    input  logic [NUM_SRC-1:0]       src_valid_i,
    output logic [NUM_SRC-1:0]       src_ready_o,
    output logic [NUM_SRC-1:0]       grant_o,
    output logic [NUM_SRC-1:0]       done_o,
    output logic [NUM_SRC-1:0]       err_o,
    output logic [7:0]               protoStream_o,
    output logic                     protoStream_valid_o,
    output logic [31:0]              dest_base_addr_o,
    output logic                     deser_reset_o,
    output logic                     busy_o
);

    localparam int IDX_W   = idx_w(NUM_SRC);
    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam int FL_W    = $clog2(FLUSH_CYCLES + 1);

    proto_sched_state_t state, state_next;

    logic [NUM_SRC-1:0] grant_q;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   ptr;
    logic [LEN_W-1:0]   remaining;
    logic [STALL_W-1:0] stall_cnt;
    logic [FL_W-1:0]    flush_cnt;
    logic               aborted;
    logic [NUM_SRC-1:0] done_q;
    logic [NUM_SRC-1:0] err_q;
    logic [7:0]         pdata;
    logic               pvalid;
    logic [31:0]        addr_q;

    logic [NUM_SRC-1:0] req_m;
    logic [NUM_SRC-1:0] win_oh;
    logic [IDX_W-1:0]   widx;
    logic               any_req;
    logic               sel_valid;
    logic [7:0]         sel_data;
    logic               hs;
    logic               stall_hit;
    logic               flush_last;

    // A zero-length done lands in IDLE; keep that stale request out.
    assign req_m = req_i & ~done_q;

    proto_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req_m),
        .ptr     (ptr),
        .onehot  (win_oh),
        .idx     (widx),
        .any_req (any_req)
    );

    assign sel_valid  = src_valid_i[gidx];
    assign sel_data   = src_data_i[int'(gidx)*8 +: 8];
    assign hs         = (state == STREAM) && sel_valid;
    assign stall_hit  = (state == STREAM) && !sel_valid
                      && (stall_cnt == STALL_W'(STALL_MAX - 1));
    assign flush_last = (flush_cnt == FL_W'(FLUSH_CYCLES - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT:   state_next = (remaining == '0) ? IDLE : STREAM;
            STREAM: begin
                if (hs && remaining == LEN_W'(1)) state_next = DRAIN;
                else if (stall_hit)               state_next = FLUSH;
            end
            DRAIN:   state_next = FLUSH;
            FLUSH:   if (flush_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grant_q   <= '0;
            gidx      <= '0;
            ptr       <= '0;
            remaining <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            aborted   <= 1'b0;
            done_q    <= '0;
            err_q     <= '0;
            pdata     <= '0;
            pvalid    <= 1'b0;
            addr_q    <= '0;
        end else begin
            pvalid <= 1'b0;
            done_q <= '0;
            err_q  <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q   <= win_oh;
                        gidx      <= widx;
                        remaining <= req_len_i[int'(widx)*LEN_W +: LEN_W];
                        addr_q    <= req_addr_i[int'(widx)*32 +: 32];
                        aborted   <= 1'b0;
                        ptr       <= (int'(widx) == NUM_SRC - 1)
                                   ? '0 : widx + 1'b1;
                    end
                end
                GRANT: begin
                    stall_cnt <= '0;
                    flush_cnt <= '0;
                    if (remaining == '0) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        pdata     <= sel_data;
                        pvalid    <= 1'b1;
                        remaining <= remaining - 1'b1;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                        if (stall_hit) begin
                            err_q   <= grant_q;
                            aborted <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_last) grant_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        src_ready_o         = (state == STREAM) ? grant_q : '0;
        grant_o             = grant_q;
        done_o              = done_q;
        if (state == FLUSH && flush_last && !aborted)
            done_o          = done_q | grant_q;
        err_o               = err_q;
        protoStream_o       = pdata;
        protoStream_valid_o = pvalid;
        dest_base_addr_o    = addr_q;
        deser_reset_o       = (state == FLUSH);
        busy_o              = (state != IDLE);
    end

endmodule

// File: tb/tb_proto_stream_sched.sv
// Randomised and directed bench for proto_stream_sched against a
// schedule-based reference model of message grant/stream/flush timing.
module tb_proto_stream_sched;

    localparam int N  = 4;
    localparam int LW = 16;
    localparam int SM = 8;
    localparam int FC = 2;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_i;
    logic [N*LW-1:0]   req_len_i;
    logic [N*32-1:0]   req_addr_i;
    logic [N*8-1:0]    src_data_i;
    logic [N-1:0]      src_valid_i;
    logic [N-1:0]      src_ready_o;
    logic [N-1:0]      grant_o;
    logic [N-1:0]      done_o;
    logic [N-1:0]      err_o;
    logic [7:0]        protoStream_o;
    logic              protoStream_valid_o;
    logic [31:0]       dest_base_addr_o;
    logic              deser_reset_o;
    logic              busy_o;

    always #5 clk = ~clk;

    proto_stream_sched #(
        .NUM_SRC      (N),
        .LEN_W        (LW),
        .STALL_MAX    (SM),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .req_i               (req_i),
        .req_len_i           (req_len_i),
        .req_addr_i          (req_addr_i),
        .src_data_i          (src_data_i),
        .src_valid_i         (src_valid_i),
        .src_ready_o         (src_ready_o),
        .grant_o             (grant_o),
        .done_o              (done_o),
        .err_o               (err_o),
        .protoStream_o       (protoStream_o),
        .protoStream_valid_o (protoStream_valid_o),
        .dest_base_addr_o    (dest_base_addr_o),
        .deser_reset_o       (deser_reset_o),
        .busy_o              (busy_o)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    bit rand_mode = 0;

    // Source side: each source owns one message at a time.
    bit         s_act  [N];
    int         s_len  [N];
    int         s_idx  [N];
    int         s_stall[N];
    int         s_mode [N];
    int         s_cool [N];
    bit         s_lastv[N];
    logic [7:0] s_bytes[N][8];

    // Reference schedule for the message currently owned.
    int          m_owner, m_ptr, m_left, m_idle;
    int          g_from, stream_start, flush_from;
    int          done_at, done_src, err_at, err_src, idle_from;
    bit          m_stream, hs_prev;
    logic [7:0]  m_byte;
    logic [31:0] m_addr;

    int         log_gsrc[$];
    int         log_gcyc[$];
    int         log_done[$];
    int         log_err[$];
    logic [7:0] log_bytes[$];
    int         log_deser;

    function automatic logic [N-1:0] oh(int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                      name, cyc, act, exp);
    endtask

    task automatic clear_logs();
        log_gsrc.delete();
        log_gcyc.delete();
        log_done.delete();
        log_err.delete();
        log_bytes.delete();
        log_deser = 0;
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_left = 0; m_idle = 0;
        g_from = -100; stream_start = -100; flush_from = -100;
        done_at = -100; done_src = -1; err_at = -100; err_src = -1;
        idle_from = -1; m_stream = 0; hs_prev = 0;
        m_byte = '0; m_addr = '0;
    endtask

    task automatic src_reset();
        for (int s = 0; s < N; s++) begin
            s_act[s] = 0; s_idx[s] = 0; s_cool[s] = 0; s_lastv[s] = 0;
            s_len[s] = 0; s_stall[s] = -1; s_mode[s] = 0;
        end
        req_i = '0; src_valid_i = '0; src_data_i = '0;
        req_len_i = '0; req_addr_i = '0;
    endtask

    task automatic start_msg(int s, int len, logic [31:0] addr,
                             int stall, int mode);
        s_act[s] = 1; s_len[s] = len; s_idx[s] = 0;
        s_stall[s] = stall; s_mode[s] = mode; s_lastv[s] = 0;
        for (int i = 0; i < 8; i++) s_bytes[s][i] = 8'($urandom);
        req_len_i[s*LW +: LW] = LW'(len);
        req_addr_i[s*32 +: 32] = addr;
    endtask

    task automatic sources_update(logic [N-1:0] fin);
        int len;
        for (int s = 0; s < N; s++) begin
            if (fin[s]) begin
                s_act[s]  = 0;
                s_cool[s] = 1 + $urandom_range(0, 3);
            end else if (!s_act[s] && rand_mode) begin
                if (s_cool[s] > 0) s_cool[s]--;
                else if ($urandom_range(0, 3) == 0) begin
                    len = $urandom_range(0, 6);
                    start_msg(s, len, $urandom,
                              (len > 0 && $urandom_range(0, 9) == 0)
                                ? $urandom_range(0, len - 1) : -1,
                              $urandom_range(0, 2));
                end
            end
        end
    endtask

    task automatic drive_inputs();
        bit can, v;
        for (int s = 0; s < N; s++) begin
            req_i[s] = s_act[s];
            can = s_act[s] && s_idx[s] < s_len[s]
               && (s_stall[s] < 0 || s_idx[s] < s_stall[s]);
            case (s_mode[s])
                0:       v = can;
                1:       v = can && !s_lastv[s];
                default: v = can && ($urandom_range(0, 3) != 0);
            endcase
            s_lastv[s] = v;
            src_valid_i[s] = v;
            if (v) src_data_i[s*8 +: 8] = s_bytes[s][s_idx[s]];
            else   src_data_i[s*8 +: 8] = 8'($urandom);
        end
    endtask

    task automatic model_advance(logic [N-1:0] fin);
        logic [N-1:0] rq;
        bit hs;
        hs = 0;
        if (m_owner < 0) begin
            rq = req_i & ~fin;
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (m_owner < 0 && rq[j]) m_owner = j;
            end
            if (m_owner >= 0) begin
                m_ptr  = (m_owner + 1) % N;
                m_addr = req_addr_i[m_owner*32 +: 32];
                m_left = int'(req_len_i[m_owner*LW +: LW]);
                g_from = cyc + 1;
                log_gsrc.push_back(m_owner);
                log_gcyc.push_back(g_from);
                if (m_left == 0) begin
                    done_at = cyc + 2; done_src = m_owner;
                    idle_from = cyc + 2;
                    log_done.push_back(done_at);
                end else begin
                    m_stream = 1; stream_start = cyc + 2; m_idle = 0;
                end
            end
        end else if (m_stream && cyc >= stream_start) begin
            if (src_valid_i[m_owner]) begin
                hs = 1;
                m_byte = src_data_i[m_owner*8 +: 8];
                log_bytes.push_back(m_byte);
                m_left--; m_idle = 0;
                s_idx[m_owner]++;
                if (m_left == 0) begin
                    m_stream = 0; flush_from = cyc + 2;
                    done_at = cyc + 1 + FC; done_src = m_owner;
                    idle_from = cyc + 2 + FC;
                    log_done.push_back(done_at);
                end
            end else begin
                m_idle++;
                if (m_idle == SM) begin
                    m_stream = 0; err_at = cyc + 1; err_src = m_owner;
                    flush_from = cyc + 1; idle_from = cyc + 1 + FC;
                    log_err.push_back(err_at);
                end
            end
        end
        hs_prev = hs;
    endtask

    task automatic step();
        logic [N-1:0] eg, er, ed, ee;
        bit edr;
        @(negedge clk);
        cyc++;
        if (cyc == idle_from) m_owner = -1;
        eg  = (m_owner >= 0 && cyc >= g_from) ? oh(m_owner) : '0;
        er  = (m_owner >= 0 && m_stream && cyc >= stream_start)
            ? oh(m_owner) : '0;
        ed  = (cyc == done_at) ? oh(done_src) : '0;
        ee  = (cyc == err_at) ? oh(err_src) : '0;
        edr = (cyc >= flush_from && cyc < flush_from + FC);
        chk("grant", grant_o, eg);
        chk("ready", src_ready_o, er);
        chk("done", done_o, ed);
        chk("err", err_o, ee);
        chk("pvalid", protoStream_valid_o, hs_prev);
        chk("pdata", protoStream_o, m_byte);
        chk("addr", dest_base_addr_o, m_addr);
        chk("deser", deser_reset_o, edr);
        chk("busy", busy_o, eg != '0);
        chk("overlap", protoStream_valid_o & deser_reset_o, 0);
        if (edr) log_deser++;
        sources_update(ed | ee);
        drive_inputs();
        model_advance(ed);
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0);
        for (int s = 0; s < N; s++) p |= s_act[s];
        return p;
    endfunction

    task automatic run_quiet(string name, int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        chk(name, n < budget, 1);
    endtask

    task automatic check_zero(string name);
        chk(name, {grant_o, src_ready_o, done_o, err_o,
                   protoStream_valid_o, protoStream_o,
                   dest_base_addr_o, deser_reset_o, busy_o}, 0);
    endtask

    initial begin
        int n;
        reset_i = 1'b1;
        src_reset();
        model_reset();
        clear_logs();
        #3 check_zero("por_outputs");
        @(posedge clk);
        @(posedge clk);
        #2 reset_i = 1'b0;

        // Four len=1 requesters, source 0 returns once: 0,1,2,3,0.
        for (int s = 0; s < N; s++) start_msg(s, 1, 32'h100 + s, -1, 0);
        n = 0;
        while (s_act[0] && n < 100) begin step(); n++; end
        start_msg(0, 1, 32'h200, -1, 0);
        run_quiet("rr_timeout", 200);
        chk("rr_count", log_gsrc.size(), 5);
        chk("rr_g0", log_gsrc[0], 0);
        chk("rr_g1", log_gsrc[1], 1);
        chk("rr_g2", log_gsrc[2], 2);
        chk("rr_g3", log_gsrc[3], 3);
        chk("rr_g4", log_gsrc[4], 0);
        chk("rr_gap", log_gcyc[1] - log_gcyc[0], 6);

        // Zero-length message on source 1.
        clear_logs();
        start_msg(1, 0, 32'hB000_0000, -1, 0);
        run_quiet("len0_timeout", 50);
        chk("len0_grant", log_gsrc[0], 1);
        chk("len0_done_lat", log_done[0] - log_gcyc[0], 1);
        chk("len0_deser", log_deser, 0);
        chk("len0_bytes", log_bytes.size(), 0);

        // Source 2, len 4, one idle cycle between bytes.
        clear_logs();
        start_msg(2, 4, 32'hC000_0040, -1, 1);
        run_quiet("gap_timeout", 80);
        chk("gap_nbytes", log_bytes.size(), 4);
        chk("gap_done_lat", log_done[0] - log_gcyc[0], 10);

        // Source 0 len 5 stalls after 2 bytes; source 1 waits behind it.
        clear_logs();
        start_msg(0, 5, 32'hD000_0000, 2, 0);
        start_msg(1, 1, 32'hD100_0000, -1, 0);
        run_quiet("stall_timeout", 100);
        chk("stall_g0", log_gsrc[0], 0);
        chk("stall_g1", log_gsrc[1], 1);
        chk("stall_err_lat", log_err[0] - log_gcyc[0], 11);
        chk("stall_next_grant", log_gcyc[1] - log_gcyc[0], 14);
        chk("stall_ndone", log_done.size(), 1);
        chk("stall_deser", log_deser, 4);

        // Single source 0: 0x08 0x96 0x01, continuous valid.
        clear_logs();
        start_msg(0, 3, 32'hA000_0010, -1, 0);
        s_bytes[0][0] = 8'h08;
        s_bytes[0][1] = 8'h96;
        s_bytes[0][2] = 8'h01;
        run_quiet("single_timeout", 50);
        chk("single_nbytes", log_bytes.size(), 3);
        chk("single_b0", log_bytes[0], 8'h08);
        chk("single_b1", log_bytes[1], 8'h96);
        chk("single_b2", log_bytes[2], 8'h01);
        chk("single_done_lat", log_done[0] - log_gcyc[0], 6);
        chk("single_deser", log_deser, 2);
        chk("single_addr_hold", dest_base_addr_o, 32'hA000_0010);

        // Randomised traffic.
        rand_mode = 1;
        for (int i = 0; i < 1500; i++) step();
        rand_mode = 0;
        run_quiet("rand_drain_timeout", 500);

        // Reset in the middle of a stream, pointer advanced beyond 1.
        start_msg(2, 6, 32'hE000_0000, -1, 0);
        n = 0;
        while (!(m_stream && cyc >= stream_start + 1) && n < 50) begin
            step();
            n++;
        end
        chk("mid_reach_stream", n < 50, 1);
        #2 reset_i = 1'b1;
        #1 check_zero("mid_reset_outputs");
        src_reset();
        model_reset();
        clear_logs();
        @(posedge clk);
        @(posedge clk);
        #2 reset_i = 1'b0;
        start_msg(1, 2, 32'hF100_0000, -1, 0);
        start_msg(3, 2, 32'hF300_0000, -1, 0);
        run_quiet("restart_timeout", 60);
        chk("restart_g0", log_gsrc[0], 1);
        chk("restart_g1", log_gsrc[1], 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/proto_stream_sched.md
# proto_stream_sched

Round-robin scheduler that shares one protobuf deserializer between `NUM_SRC` byte-stream sources. It grants one source at a time for exactly one length-prefixed message and forwards its bytes to the deserializer's `protoStream`/`protoStream_valid` inputs. It drives the per-message `dest_base_addr`, then pulses a deserializer flush so state never leaks between messages. It sits between the source DMA/ingress queues and the deserializer.

## Interface
- `NUM_SRC`, 4: number of sources, 2..16.
- `LEN_W`, 16: message length width in bytes.
- `STALL_MAX`, 1024: idle cycles allowed in STREAM before abort.
- `FLUSH_CYCLES`, 2: cycles `deser_reset_o` is held, ≥1.
- `clk_i`  in  1  clock; one clock domain.
- `reset_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  NUM_SRC  source has a message pending; held until `done_o` or `err_o`.
- `req_len_i`  in  NUM_SRC*LEN_W  message byte count; stable while `req_i` is high.
- `req_addr_i`  in  NUM_SRC*32  destination base address for the message.
- `src_data_i`  in  NUM_SRC*8  source byte.
- `src_valid_i`  in  NUM_SRC  byte valid.
- `src_ready_o`  out  NUM_SRC  byte accepted when valid&ready.
- `grant_o`  out  NUM_SRC  one-hot current owner; 0 when idle.
- `done_o`  out  NUM_SRC  one-cycle pulse: message fully forwarded and flushed.
- `err_o`  out  NUM_SRC  one-cycle pulse: message aborted on stall.
- `protoStream_o`  out  8  byte to deserializer.
- `protoStream_valid_o`  out  1  byte valid to deserializer.
- `dest_base_addr_o`  out  32  base address for the deserializer.
- `deser_reset_o`  out  1  flush to deserializer; top level ORs it with `reset_i`.
- `busy_o`  out  1  state != IDLE.

## Operation
- All outputs reset to 0. Round-robin pointer resets to 0. State resets to IDLE.
- IDLE: if any `req_i` is high, pick the first requester at or after the pointer, with wrap-around. Register `grant_o`, length into `remaining`, and the address into `dest_base_addr_o`. Go to GRANT. Set pointer to winner+1 modulo NUM_SRC.
- GRANT (1 cycle): if `remaining`==0, pulse `done_o[g]`, clear the grant, and go to IDLE with no flush. Otherwise go to STREAM.
- STREAM: `src_ready_o[g]` = 1, and it is driven combinationally from state and grant. All other ready bits are 0.
  - Each handshake registers the byte onto `protoStream_o`, asserts `protoStream_valid_o` next cycle, decrements `remaining`, and clears the stall counter.
  - Gaps in `src_valid_i` are allowed; `protoStream_valid_o` is low during gaps.
  - Handshake with `remaining`==1 goes to DRAIN.
  - Stall counter reaching `STALL_MAX` pulses `err_o[g]` and goes to FLUSH. `done_o` is not asserted.
- DRAIN (1 cycle): the last byte is presented to the deserializer. Go to FLUSH.
- FLUSH: `deser_reset_o`=1 for FLUSH_CYCLES cycles; `protoStream_valid_o`=0.
  - On a normal end, the last FLUSH cycle pulses `done_o[g]`.
  - Next state is IDLE; `grant_o` clears on entry to IDLE.
- `dest_base_addr_o` is stable from GRANT through FLUSH. It holds its last value in IDLE.
- `remaining` is LEN_W bits and never underflows: the decrement only happens in STREAM with `remaining`≥1.
- A source that keeps `req_i` high after `done_o` is treated as presenting a new message. It is re-arbitrated in the following IDLE cycle.
- Reset mid-message drops all state immediately, including pointer, counters and grant. The bytes in flight are lost.

## Timing
- Arbitration latency: first request seen in IDLE at cycle 0 → `grant_o` at cycle 1. `src_ready_o` is high from cycle 2.
- Byte latency: handshake at T → `protoStream_valid_o` at T+1, exactly one cycle.
- Last handshake at T:
  - DRAIN at T+1.
  - `deser_reset_o` high for T+2..T+1+FLUSH_CYCLES.
  - `done_o` at T+1+FLUSH_CYCLES.
  - Earliest next grant at T+3+FLUSH_CYCLES.
- Throughput is one byte per cycle while valid stays high.
- `protoStream_valid_o` and `deser_reset_o` are never high in the same cycle.

## Structure
- Add the state enum `proto_sched_state_t` (IDLE, GRANT, STREAM, DRAIN, FLUSH) to `protobuf_pkg`.
- Sub-module `proto_rr_arbiter`:
  - Inputs: req vector and pointer.
  - Outputs: one-hot winner, winner index, any_req.
  - Combinational, parameterized by NUM_SRC.
- Sequencing FSM, counters and datapath registers live in the top module.

## Test plan
- Single source, len=3, bytes 0x08,0x96,0x01, continuous valid → stream valid on 3 consecutive cycles, same bytes; `dest_base_addr_o`=req_addr; `deser_reset_o` 2 cycles; `done_o[0]` one pulse.
- All 4 sources requesting, len=1 each → grants in order 0,1,2,3,0; no overlap; ready only on the granted source.
- Source 2 len=4 with one idle cycle between every byte → 4 valid bytes with gaps; no early DRAIN.
- len=0 on source 1 → `done_o[1]` at GRANT+1; no `deser_reset_o`; no valid bytes.
- Source stops after 2 of 5 bytes, STALL_MAX=8 → `err_o` after 8 idle cycles; flush asserted; no `done_o`; next source granted.
- `reset_i` asserted mid-STREAM → all outputs 0 asynchronously; pointer 0; clean restart on the next request.
